// File: rtl/rename_stage_pkg.sv
// Shared types and sizing for the register-rename stage.
package rename_stage_pkg;

  localparam int ARCH_REGS_C = 32;
  localparam int PHYS_REGS_C = 64;
  localparam int PREG_W_C    = $clog2(PHYS_REGS_C);
  localparam int FL_DEPTH_C  = PHYS_REGS_C - ARCH_REGS_C;

  typedef logic [PREG_W_C-1:0] preg_t;
  typedef logic [4:0]          areg_t;

  typedef struct packed {
    logic [6:0] opcode;
    areg_t      rs1;
    areg_t      rs2;
    areg_t      rd;
    logic       regwrite;
  } decode_data;

  typedef struct packed {
    decode_data dec;
    preg_t      prs1;
    preg_t      prs2;
    preg_t      prd;
    preg_t      old_prd;
  } rename_data;

endpackage

// File: rtl/rename_stage_if.sv
// Decode-in / dispatch-out stream plus the commit free port of the rename stage.
interface rename_stage_if;
  import rename_stage_pkg::*;

  logic       valid_in;
  decode_data data_in;
  logic       ready_in;
  logic       valid_out;
  rename_data data_out;
  logic       ready_out;
  logic       free_valid;
  preg_t      free_preg;

  modport master (
    output valid_in, data_in, ready_out, free_valid, free_preg,
    input  ready_in, valid_out, data_out
  );

  modport slave (
    input  valid_in, data_in, ready_out, free_valid, free_preg,
    output ready_in, valid_out, data_out
  );
endinterface

// File: rtl/rename_stage_free_list.sv
// Circular FIFO of free physical registers, preloaded with BASE..BASE+DEPTH-1.
module rename_stage_free_list
  import rename_stage_pkg::*;
#(
  parameter int DEPTH = FL_DEPTH_C,
  parameter int BASE  = ARCH_REGS_C
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         pop,
  input  logic                         push,
  input  preg_t                        push_data,
  output preg_t                        head_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL    = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  preg_t            mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             push_ok;
  logic             pop_ok;

  // Illegal pushes (overflow or p0) are dropped so the list stays consistent.
  assign push_ok   = push && (count != FULL) && (push_data != '0);
  assign pop_ok    = pop && (count != '0);
  assign head_data = mem[head];

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= preg_t'(BASE + i);
      head  <= '0;
      tail  <= '0;
      count <= FULL;
    end else begin
      if (push) begin
        assert (count != FULL);
        assert (push_data != '0);
      end
      if (push_ok) begin
        mem[tail] <= push_data;
        tail      <= next_ptr(tail);
      end
      if (pop_ok) head <= next_ptr(head);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rename_stage.sv
// Register-rename stage: RAT lookup/update, free-list pop, registered output toward dispatch.
module rename_stage
  import rename_stage_pkg::*;
#(
  parameter int ARCH_REGS = ARCH_REGS_C,
  parameter int PHYS_REGS = PHYS_REGS_C
) (
  input logic           clk,
  input logic           reset,
  rename_stage_if.slave bus
);
  localparam int FL_DEPTH = PHYS_REGS - ARCH_REGS;
  localparam int CNT_W    = $clog2(FL_DEPTH + 1);

  preg_t            rat [ARCH_REGS];
  preg_t            fl_head;
  logic [CNT_W-1:0] fl_count;
  logic             accept;
  logic             do_write;

  assign bus.ready_in = (~bus.valid_out | bus.ready_out) & (fl_count != '0);
  assign accept       = bus.valid_in & bus.ready_in;
  assign do_write     = accept & bus.data_in.regwrite & (bus.data_in.rd != '0);

  rename_stage_free_list #(
    .DEPTH (FL_DEPTH),
    .BASE  (ARCH_REGS)
  ) u_fl (
    .clk       (clk),
    .reset     (reset),
    .pop       (do_write),
    .push      (bus.free_valid),
    .push_data (bus.free_preg),
    .head_data (fl_head),
    .count     (fl_count)
  );

  // rat[0] is only ever written by reset, so it always maps x0 to p0.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ARCH_REGS; i++) rat[i] <= preg_t'(i);
    end else if (do_write) begin
      rat[bus.data_in.rd] <= fl_head;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.valid_out <= 1'b0;
      bus.data_out  <= '0;
    end else if (accept) begin
      bus.valid_out         <= 1'b1;
      bus.data_out.dec      <= bus.data_in;
      bus.data_out.prs1     <= rat[bus.data_in.rs1];
      bus.data_out.prs2     <= rat[bus.data_in.rs2];
      bus.data_out.prd      <= do_write ? fl_head : '0;
      bus.data_out.old_prd  <= do_write ? rat[bus.data_in.rd] : '0;
    end else if (bus.ready_out) begin
      bus.valid_out <= 1'b0;
    end
  end

endmodule

// File: doc/rename_stage.md
Name: rename_stage

Overview:
- Register-rename stage; the consumer end of the decode-side valid/ready stream.
- Accepts one decode_data per cycle.
- Maps architectural source and destination registers to physical registers through a register alias table (RAT) and a circular free list.
- Emits one registered rename_data per cycle toward dispatch. Commit returns freed physical registers through a separate port.

Parameters:
ARCH_REGS, 32, number of architectural registers (x0 hardwired to p0)
PHYS_REGS, 64, number of physical registers
FL_DEPTH, PHYS_REGS-ARCH_REGS, free-list capacity (32)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
valid_in  in  1  decode_data valid from the upstream decode skid buffer
data_in  in  decode_data  decoded instruction; uses fields rs1, rs2, rd (5b) and regwrite
ready_in  out  1  stage can accept data_in this cycle
valid_out  out  1  rename_data valid toward dispatch
data_out  out  rename_data  renamed instruction
ready_out  in  1  dispatch can accept data_out
free_valid  in  1  commit returns one physical register
free_preg  in  PREG_W  physical register being freed (1..PHYS_REGS-1)

Behaviour:
- PREG_W = $clog2(PHYS_REGS) = 6.
- Reset (sync, clk edge while reset=1):
  - RAT[i] = i for all i.
  - Free list holds ARCH_REGS..PHYS_REGS-1 in ascending order; head=0, tail=0, count=FL_DEPTH.
  - valid_out=0, data_out='0.
  - Reset overrides every concurrent handshake, including a free_valid in the same cycle.
- Readiness: ready_in = (~valid_out | ready_out) & (count != 0).
  - Does not depend on valid_in or regwrite; count is the registered value.
- Accept when valid_in & ready_in. Latency 1 cycle: data_out and valid_out are registered.
- Rename on accept:
  - data_out carries all decode_data fields.
  - prs1 = RAT[rs1], prs2 = RAT[rs2], read from the pre-update RAT.
  - If regwrite && rd != 0: prd = free_list[head], old_prd = RAT[rd], RAT[rd] <= prd, head++ (mod FL_DEPTH), pop.
  - Otherwise prd=0, old_prd=0, no pop, no RAT write.
- RAT[0] is never written and always reads 0.
- Back-to-back dependency: the instruction accepted in cycle N+1 sees the RAT update from cycle N.
- Output hold: if valid_out & ~ready_out, data_out and valid_out stay stable and ready_in=0.
- Output drain: if valid_out & ready_out with no accept, valid_out<=0 next cycle.
- Free path: free_valid pushes free_preg at tail, tail++ (mod FL_DEPTH).
  - A freed register becomes usable the next cycle; no same-cycle bypass to head.
- Count update: count += push - pop. Simultaneous push and pop leaves count unchanged.
- Boundaries:
  - count==0: ready_in=0; upstream stalls.
  - Push when count==FL_DEPTH is illegal: assertion fires, push is dropped, state is unchanged.
  - free_preg==0 is illegal: assertion fires, push is dropped.
  - head and tail wrap from FL_DEPTH-1 to 0.
- No flush or recovery in this revision.

Decomposition:
- types_pkg:
  - constants ARCH_REGS_C, PHYS_REGS_C, PREG_W_C
  - typedef preg_t = logic [PREG_W_C-1:0]
  - typedef rename_data = struct of decode_data fields plus prs1, prs2, prd, old_prd (preg_t)
- One sub-module, free_list: circular FIFO of preg_t.
  - Ports: pop, push, push_data, head_data, count.
  - Reset preload as above.
- RAT and the output register stay in rename_stage.

Test Plan:
1. Reset, then accept rs1=1, rs2=2, rd=5, regwrite=1, ready_out=1 -> next cycle valid_out=1, prs1=1, prs2=2, prd=32, old_prd=5; count 32->31.
2. RAW chain: rd=5 write, then rs1=5, rd=6 back-to-back -> second has prs1=32, prd=33, old_prd=6.
3. rd=0 with regwrite=1, then regwrite=0 rd=7 -> both prd=0, old_prd=0; count unchanged; RAT[7] still 7.
4. 32 consecutive writes to x1 with no frees -> prds 32..63, ready_in=0 after the 32nd. Then free_valid=1, free_preg=9 -> ready_in=1 the following cycle; next write gets prd=9.
5. Backpressure: ready_out=0 for 3 cycles with valid_out=1 -> data_out bit-stable, ready_in=0, no pops. Simultaneous free and accept at count=1 -> count stays 1.
6. reset=1 mid-stream with valid_in=1 and free_valid=1 -> next cycle valid_out=0, count=32, RAT identity, first post-reset write gets prd=32.
